timer_counter: RTL and testbench

Memory-mapped programmable countdown timer that produces a hardware interrupt request for the CP0 exception unit. It sits on the CPU's data-memory bridge and is the interrupt source that CP0 services. Software programs a preset, enable, mode and interrupt mask through word-aligned loads and stores. The timer asserts `IRQ` when the count expires.

---
 rtl/timer_counter.sv | 68 ++++++
 tb/tb_timer_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer raising a level interrupt for CP0
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
  logic        w_hit;
  logic [3:0]  w_reg;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  assign w_hit     = Addr[31:4] == BASE[31:4];
  assign w_reg     = Addr[3:0] >> 2;
  assign w_wr_ctrl = WE && w_hit && w_reg == 4'd0;
  assign w_wr_pre  = WE && w_hit && w_reg == 4'd1;
  assign IRQ       = r_ctrl[3] & r_irq;
  // read mux: selected register inside the window, zero elsewhere
  always_comb
    Dout = !w_hit ? 32'd0 :
           w_reg == 4'd0 ? {28'd0, r_ctrl} :
           w_reg == 4'd1 ? r_preset :
           w_reg == 4'd2 ? r_count : 32'd0;
  // countdown FSM; a software CTRL write comes last so it overrides the INT-state EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_pre) r_preset <= Din;
      case (r_state)
        IDLE: if (r_ctrl[0]) r_state <= LOAD;
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT:
          if (!r_ctrl[0]) r_state <= IDLE;
          else if (r_count == 32'd0) begin
            r_state <= INT;
            r_irq   <= 1'b1;
          end else r_count <= r_count - 32'd1;
        default: begin
          r_state <= IDLE;
          if (r_ctrl[2:1] == 2'b01) r_irq <= 1'b0;
          else r_ctrl[0] <= 1'b0;
        end
      endcase
      if (w_wr_ctrl) begin
        r_ctrl <= Din[3:0];
        r_irq  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scoreboard bench for the countdown timer
`timescale 1ns/1ps
module tb_timer_counter;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE, A_PRE = BASE + 32'h4, A_CNT = BASE + 32'h8, A_RSV = BASE + 32'hC;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] q_exp[$];
  string       q_tag[$];
  timer_counter #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );
  always #10 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] e, input string tag);
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask
  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    push(e, tag);
    Addr = a;
    #1;
    check(Dout);
  endtask
  task automatic irq_is(input logic e, input string tag);
    push({31'd0, e}, tag);
    #1;
    check({31'd0, IRQ});
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din = d;
    WE = 1'b1;
    step();
    WE = 1'b0;
    Addr = 32'd0;
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_PRE, 0, "rst_pre");
    rd(A_CNT, 0, "rst_cnt");
    rd(A_RSV, 0, "rst_rsv");
    irq_is(0, "rst_irq");
    // one-shot, PRESET=3
    wr(A_PRE, 3);
    wr(A_CTRL, 32'h9);
    step();
    for (int k = 2; k <= 5; k++) begin
      step();
      rd(A_CNT, 32'(5 - k), $sformatf("os_cnt_E%0d", k));
      irq_is(0, $sformatf("os_irq_lo_E%0d", k));
    end
    step();
    irq_is(1, "os_irq_E6");
    step();
    rd(A_CTRL, 32'h8, "os_ctrl_E7");
    irq_is(1, "os_irq_E7");
    step();
    step();
    irq_is(1, "os_irq_hold");
    wr(A_CTRL, 0);
    irq_is(0, "os_irq_clear");
    // auto-reload, PRESET=2: one-cycle pulse every 6 cycles
    wr(A_PRE, 2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      step();
      irq_is(k >= 5 && (k - 5) % 6 == 0, $sformatf("ar_irq_E%0d", k));
    end
    wr(A_CTRL, 0);
    repeat (3) step();
    // disable mid-count freezes COUNT; re-enable reloads
    wr(A_PRE, 10);
    wr(A_CTRL, 32'h1);
    repeat (5) step();
    rd(A_CNT, 7, "frz_pre");
    wr(A_CTRL, 32'h8);
    rd(A_CNT, 6, "frz_at");
    repeat (4) step();
    rd(A_CNT, 6, "frz_hold");
    irq_is(0, "frz_irq");
    wr(A_PRE, 12);
    rd(A_CNT, 6, "frz_prewr");
    wr(A_CTRL, 32'h9);
    step();
    step();
    rd(A_CNT, 12, "reload");
    wr(A_CTRL, 0);
    repeat (3) step();
    // PRESET=0, IM=0: INT reached but IRQ masked
    wr(A_PRE, 0);
    wr(A_CTRL, 32'h1);
    step();
    step();
    rd(A_CNT, 0, "p0_cnt");
    rd(A_CTRL, 32'h1, "p0_ctrl_en");
    step();
    irq_is(0, "p0_irq_int");
    step();
    rd(A_CTRL, 0, "p0_en_clr");
    irq_is(0, "p0_irq_masked");
    wr(A_CNT, 32'h55);
    rd(A_CNT, 0, "cnt_ro");
    wr(A_RSV, 32'hFFFF_FFFF);
    rd(A_RSV, 0, "rsv_ro");
    rd(A_PRE, 0, "rsv_pre");
    wr(A_CTRL, 32'hFFFF_FFF4);
    rd(A_CTRL, 32'h4, "ctrl_upper");
    wr(A_CTRL, 0);
    // out-of-window writes and reset mid-count
    wr(BASE + 32'h14, 32'h1234);
    rd(A_PRE, 0, "oow_pre");
    wr(BASE + 32'h10, 32'hF);
    rd(A_CTRL, 0, "oow_ctrl");
    rd(BASE + 32'h14, 0, "oow_read");
    wr(A_PRE, 20);
    wr(A_CTRL, 32'h9);
    repeat (4) step();
    rd(A_CNT, 18, "pre_rst_cnt");
    reset = 1'b1;
    Addr = A_PRE;
    Din = 32'h5;
    WE = 1'b1;
    step();
    reset = 1'b0;
    WE = 1'b0;
    rd(A_CTRL, 0, "mrst_ctrl");
    rd(A_PRE, 0, "mrst_pre");
    rd(A_CNT, 0, "mrst_cnt");
    irq_is(0, "mrst_irq");
    repeat (3) step();
    rd(A_CNT, 0, "mrst_idle_cnt");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
